// File: rtl/integration_sysid_checker_if.sv
// Avalon-MM read-only master bundle used to fetch the two sysid words.
// Zero read latency: readdata is valid in the cycle that waitrequest is low.
interface integration_sysid_checker_if;
    logic        avm_address;
    logic        avm_read;
    logic        avm_waitrequest;
    logic [31:0] avm_readdata;

    modport master (
        output avm_address,
        output avm_read,
        input  avm_waitrequest,
        input  avm_readdata
    );

    modport slave (
        input  avm_address,
        input  avm_read,
        output avm_waitrequest,
        output avm_readdata
    );
endinterface

// File: rtl/integration_sysid_checker.sv
// Reads sysid ID and timestamp words on start and compares them with the expected build.
// Latency: done rises 3 cycles after the start cycle when the slave never stalls.
// Backpressure: waitrequest holds the read; TIMEOUT_CYCLES stalls abort to DONE with timeout.
module integration_sysid_checker #(
    parameter logic [31:0] EXPECTED_ID        = 32'h53345055,
    parameter logic [31:0] EXPECTED_TIMESTAMP = 32'h5BEC6CC9,
    parameter int unsigned TIMEOUT_CYCLES     = 16
) (
    input  logic                               clock,
    input  logic                               reset_n,
    input  logic                               start,
    integration_sysid_checker_if.master        avm,
    output logic [31:0]                        id_value,
    output logic [31:0]                        ts_value,
    output logic                               busy,
    output logic                               done,
    output logic                               id_ok,
    output logic                               ts_ok,
    output logic                               timeout
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RD_ID = 2'd1,
        RD_TS = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [7:0] STALL_LIMIT = 8'(TIMEOUT_CYCLES);

    state_t      state_q, state_d;
    logic [7:0]  stall_q, stall_d;
    logic [31:0] id_value_q, id_value_d;
    logic [31:0] ts_value_q, ts_value_d;
    logic        id_ok_q, id_ok_d;
    logic        ts_ok_q, ts_ok_d;
    logic        timeout_q, timeout_d;

    logic        rd_active;
    logic        rd_addr;
    logic        accept;
    logic        stall_hit;
    logic        launch;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            stall_q    <= 8'd0;
            id_value_q <= 32'd0;
            ts_value_q <= 32'd0;
            id_ok_q    <= 1'b0;
            ts_ok_q    <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            stall_q    <= stall_d;
            id_value_q <= id_value_d;
            ts_value_q <= ts_value_d;
            id_ok_q    <= id_ok_d;
            ts_ok_q    <= ts_ok_d;
            timeout_q  <= timeout_d;
        end
    end

    // An accept needs waitrequest low and a stall hit needs it high, so they
    // never coincide; accept is still tested first to make its priority explicit.
    always_comb begin
        accept    = rd_active && !avm.avm_waitrequest;
        stall_hit = rd_active && avm.avm_waitrequest && ((stall_q + 8'd1) == STALL_LIMIT);
        launch    = ((state_q == IDLE) || (state_q == DONE)) && start;
        state_d   = state_q;
        case (state_q)
            IDLE:    if (start) state_d = RD_ID;
            RD_ID:   if (accept) state_d = RD_TS;
                     else if (stall_hit) state_d = DONE;
            RD_TS:   if (accept || stall_hit) state_d = DONE;
            DONE:    if (start) state_d = RD_ID;
            default: state_d = IDLE;
        endcase

        if (state_d != state_q) begin
            stall_d = 8'd0;
        end else if (rd_active && avm.avm_waitrequest) begin
            stall_d = stall_q + 8'd1;
        end else begin
            stall_d = stall_q;
        end
    end

    always_comb begin
        id_value_d = id_value_q;
        ts_value_d = ts_value_q;
        id_ok_d    = id_ok_q;
        ts_ok_d    = ts_ok_q;
        timeout_d  = timeout_q;
        if (launch) begin
            id_ok_d   = 1'b0;
            ts_ok_d   = 1'b0;
            timeout_d = 1'b0;
        end
        if (accept && (state_q == RD_ID)) begin
            id_value_d = avm.avm_readdata;
            id_ok_d    = (avm.avm_readdata == EXPECTED_ID);
        end
        if (accept && (state_q == RD_TS)) begin
            ts_value_d = avm.avm_readdata;
            ts_ok_d    = (avm.avm_readdata == EXPECTED_TIMESTAMP);
        end
        if (stall_hit && !accept) begin
            timeout_d = 1'b1;
        end
    end

    always_comb begin
        rd_active = (state_q == RD_ID) || (state_q == RD_TS);
        rd_addr   = (state_q == RD_TS);
    end

    assign avm.avm_read    = rd_active;
    assign avm.avm_address = rd_addr;
    assign busy            = rd_active;
    assign done            = (state_q == DONE);
    assign id_value        = id_value_q;
    assign ts_value        = ts_value_q;
    assign id_ok           = id_ok_q;
    assign ts_ok           = ts_ok_q;
    assign timeout         = timeout_q;

endmodule

// File: tb/tb_integration_sysid_checker.sv
// Bench for integration_sysid_checker: table of slave behaviours plus reset and restart sequences.
module tb_integration_sysid_checker;

    localparam logic [31:0] GOOD_ID = 32'h53345055;
    localparam logic [31:0] GOOD_TS = 32'h5BEC6CC9;
    localparam int          TO      = 16;

    logic        clock;
    logic        reset_n;
    logic        start;
    logic [31:0] id_value, ts_value;
    logic        busy, done, id_ok, ts_ok, timeout;
    logic        wr;
    logic [31:0] id_word, ts_word;

    integration_sysid_checker_if avm_if ();

    assign avm_if.avm_waitrequest = wr;
    assign avm_if.avm_readdata    = avm_if.avm_address ? ts_word : id_word;

    integration_sysid_checker dut (
        .clock    (clock),
        .reset_n  (reset_n),
        .start    (start),
        .avm      (avm_if),
        .id_value (id_value),
        .ts_value (ts_value),
        .busy     (busy),
        .done     (done),
        .id_ok    (id_ok),
        .ts_ok    (ts_ok),
        .timeout  (timeout)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic [31:0] id_word;
        logic [31:0] ts_word;
        int          stall_id;
        int          stall_ts;
        logic        exp_id_ok;
        logic        exp_ts_ok;
        logic        exp_timeout;
        int          exp_lat;
    } vec_t;

    typedef struct {
        logic [31:0] id_value;
        logic [31:0] ts_value;
        logic        id_ok;
        logic        ts_ok;
        logic        timeout;
        int          lat;
    } exp_t;

    vec_t        vecs[8];
    exp_t        sb_q[$];
    int          checks   = 0;
    int          failures = 0;
    logic [31:0] m_id, m_ts;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, " avm_read"}, 32'(avm_if.avm_read), 32'd0);
        chk({tag, " avm_address"}, 32'(avm_if.avm_address), 32'd0);
        chk({tag, " busy"}, 32'(busy), 32'd0);
        chk({tag, " done"}, 32'(done), 32'd0);
        chk({tag, " id_ok"}, 32'(id_ok), 32'd0);
        chk({tag, " ts_ok"}, 32'(ts_ok), 32'd0);
        chk({tag, " timeout"}, 32'(timeout), 32'd0);
        chk({tag, " id_value"}, id_value, 32'd0);
        chk({tag, " ts_value"}, ts_value, 32'd0);
    endtask

    // Expected values and flags come from the table; retained registers from the model.
    task automatic run_check(input vec_t v, input int extra_start, input string tag);
        exp_t e;
        int   cyc, wid, wts;
        bit   got, prev_stall, prev_addr;
        e.id_ok   = v.exp_id_ok;
        e.ts_ok   = v.exp_ts_ok;
        e.timeout = v.exp_timeout;
        e.lat     = v.exp_lat;
        if (v.stall_id < TO) m_id = v.id_word;
        if (v.stall_id < TO && v.stall_ts < TO) m_ts = v.ts_word;
        e.id_value = m_id;
        e.ts_value = m_ts;
        sb_q.push_back(e);

        id_word = v.id_word;
        ts_word = v.ts_word;
        cyc = 0; wid = 0; wts = 0; got = 0; prev_stall = 0; prev_addr = 0;
        while (cyc < 100 && !got) begin
            start = (cyc == 0) || (cyc == extra_start);
            if (avm_if.avm_read)
                wr = avm_if.avm_address ? (wts < v.stall_ts) : (wid < v.stall_id);
            else
                wr = 1'b0;
            if (prev_stall && avm_if.avm_read)
                chk({tag, " address held"}, 32'(avm_if.avm_address), 32'(prev_addr));
            prev_stall = avm_if.avm_read && wr;
            prev_addr  = avm_if.avm_address;
            @(posedge clock);
            if (avm_if.avm_read && wr) begin
                if (avm_if.avm_address) wts++;
                else wid++;
            end
            #1;
            cyc++;
            if (cyc == 1) begin
                chk({tag, " busy after start"}, 32'(busy), 32'd1);
                chk({tag, " flags cleared"}, {28'd0, done, id_ok, ts_ok, timeout}, 32'd0);
            end
            if (done) got = 1;
        end
        start = 1'b0;
        wr    = 1'b0;
        e = sb_q.pop_front();
        if (!got) begin
            checks++;
            failures++;
            $display("FAIL %s done wait: no done within %0d cycles, required within %0d", tag, cyc, e.lat);
        end else begin
            chk({tag, " latency"}, 32'(cyc), 32'(e.lat));
            chk({tag, " id_value"}, id_value, e.id_value);
            chk({tag, " ts_value"}, ts_value, e.ts_value);
            chk({tag, " id_ok"}, 32'(id_ok), 32'(e.id_ok));
            chk({tag, " ts_ok"}, 32'(ts_ok), 32'(e.ts_ok));
            chk({tag, " timeout"}, 32'(timeout), 32'(e.timeout));
            wr = 1'b1;
            @(posedge clock);
            #1;
            wr = 1'b0;
            chk({tag, " read low in done"}, 32'(avm_if.avm_read), 32'd0);
            chk({tag, " done held"}, 32'(done), 32'd1);
            chk({tag, " result held"}, {29'd0, id_ok, ts_ok, timeout},
                {29'd0, e.id_ok, e.ts_ok, e.timeout});
            chk({tag, " id_value held"}, id_value, e.id_value);
        end
    endtask

    initial begin
        reset_n = 1'b0;
        start   = 1'b0;
        wr      = 1'b0;
        id_word = 32'd0;
        ts_word = 32'd0;
        m_id    = 32'd0;
        m_ts    = 32'd0;

        vecs[0] = '{GOOD_ID,      GOOD_TS,      0,   0,   1'b1, 1'b1, 1'b0, 3};
        vecs[1] = '{GOOD_ID,      32'h0,        0,   0,   1'b1, 1'b0, 1'b0, 3};
        vecs[2] = '{GOOD_ID,      GOOD_TS,      5,   0,   1'b1, 1'b1, 1'b0, 8};
        vecs[3] = '{32'h12345678, GOOD_TS,      0,   3,   1'b0, 1'b1, 1'b0, 6};
        vecs[4] = '{GOOD_ID,      GOOD_TS,      15,  15,  1'b1, 1'b1, 1'b0, 33};
        vecs[5] = '{32'hA5A5A5A5, 32'h5A5A5A5A, 200, 0,   1'b0, 1'b0, 1'b1, 17};
        vecs[6] = '{GOOD_ID,      32'hDEADBEEF, 2,   200, 1'b1, 1'b0, 1'b1, 20};
        vecs[7] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1,   1,   1'b0, 1'b0, 1'b0, 5};

        repeat (2) @(posedge clock);
        #1;
        chk_all_zero("in reset");
        reset_n = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        chk("idle without start busy", 32'(busy), 32'd0);
        chk("idle without start done", 32'(done), 32'd0);
        chk("idle without start read", 32'(avm_if.avm_read), 32'd0);

        for (int i = 0; i < 8; i++) begin
            run_check(vecs[i], -1, $sformatf("vec%0d", i));
        end

        // Start during RD_ID is ignored; start in DONE restarts with cleared flags.
        run_check('{GOOD_ID, GOOD_TS, 4, 0, 1'b1, 1'b1, 1'b0, 7}, 2, "start in rd_id");
        run_check('{GOOD_ID, 32'h01020304, 3, 0, 1'b1, 1'b0, 1'b0, 6}, -1, "restart from done");

        // Reset asserted mid-read of the timestamp word.
        id_word = GOOD_ID;
        ts_word = GOOD_TS;
        start = 1'b1;
        @(posedge clock);
        #1;
        start = 1'b0;
        @(posedge clock);
        #1;
        wr = 1'b1;
        chk("rd_ts before reset read", 32'(avm_if.avm_read), 32'd1);
        chk("rd_ts before reset addr", 32'(avm_if.avm_address), 32'd1);
        #2;
        reset_n = 1'b0;
        #1;
        chk_all_zero("reset mid-read");
        @(posedge clock);
        #1;
        reset_n = 1'b1;
        wr = 1'b0;
        m_id = 32'd0;
        m_ts = 32'd0;
        repeat (3) @(posedge clock);
        #1;
        chk_all_zero("idle after reset release");
        run_check(vecs[0], -1, "after reset");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/integration_sysid_checker.md
INTEGRATION_SYSID_CHECKER -- requirements
Module: integration_sysid_checker

Interface
REQ-001 SHALL have parameter EXPECTED_ID, default 32'h53345055, meaning the system ID value expected at sysid word 0.
REQ-002 SHALL have parameter EXPECTED_TIMESTAMP, default 32'h5BEC6CC9, meaning the build timestamp expected at sysid word 1.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 16, legal range 1..255, meaning the maximum stall cycles allowed per read.
REQ-004 SHALL have port clock, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 SHALL have port reset_n, input, 1 bit: reset, asynchronous assert, active-low.
REQ-006 SHALL have port start, input, 1 bit: one-cycle request to run a check.
REQ-007 SHALL have port avm_address, output, 1 bit: sysid word select (0 = ID, 1 = timestamp).
REQ-008 SHALL have port avm_read, output, 1 bit: Avalon-MM read strobe.
REQ-009 SHALL have port avm_waitrequest, input, 1 bit: slave stall.
REQ-010 SHALL have port avm_readdata, input, 32 bits: read data, valid in the accept cycle (zero read latency).
REQ-011 SHALL have ports id_value and ts_value, outputs, 32 bits each: captured words.
REQ-012 SHALL have ports busy, done, id_ok, ts_ok, timeout, outputs, 1 bit each: status.

Function
REQ-013 SHALL implement states IDLE, RD_ID, RD_TS, DONE.
REQ-014 SHALL move IDLE->RD_ID or DONE->RD_ID on the edge where start=1, clearing done, id_ok, ts_ok and timeout on that edge.
REQ-015 SHALL ignore start in RD_ID and RD_TS.
REQ-016 SHALL drive avm_read=1 in RD_ID and RD_TS only, with avm_address=0 in RD_ID and 1 in RD_TS, held stable while avm_waitrequest=1.
REQ-017 SHALL treat a read as accepted on an edge where avm_read=1 and avm_waitrequest=0, and capture avm_readdata on that edge.
REQ-018 SHALL, on RD_ID accept, load id_value and set id_ok=(avm_readdata==EXPECTED_ID), then go to RD_TS.
REQ-019 SHALL, on RD_TS accept, load ts_value, set ts_okк=(avm_readdata==EXPECTED_TIMESTAMP), then go to DONE.
REQ-020 SHALL assert done=1 in DONE only, and busy=1 in RD_ID and RD_TS only.
REQ-021 SHALL give a fixed latency of 3 cycles from the start edge to done=1 when avm_waitrequest is held 0.
REQ-022 SHALL use an 8-bit stall counter, cleared on every state entry, incremented on each edge in RD_ID/RD_TS with avm_waitrequest=1.
REQ-023 SHALL, when the stall counter reaches TIMEOUT_CYCLES, go to DONE with timeout=1, avm_read=0 next cycle, and leave the pending word's ok flag 0 and its value register unchanged.
REQ-024 SHALL give accept priority over timeout when both occur on the same edge.
REQ-025 SHALL hold id_value, ts_value and all flags stable in DONE until the next start.

Reset
REQ-026 SHALL, while reset_n=0, immediately force state IDLE, avm_read=0, avm_address=0, busy=0, done=0, id_ok=0, ts_ok=0, timeout=0, id_value=0, ts_value=0 and stall counter=0, including mid-read.
REQ-027 SHALL stay in IDLE after reset_n deasserts until start=1.

Verification
REQ-028 Slave returns 0x53345055 then 0x5BEC6CC9 with waitrequest=0, start pulse -> done=1 3 cycles later, id_ok=1, ts_ok=1, timeout=0.
REQ-029 Slave returns 0x53345055 then 0x00000000 -> done=1, id_ok=1, ts_ok=0, ts_value=0.
REQ-030 waitrequest=1 for 5 cycles on word 0, TIMEOUT_CYCLES=16 -> address held 0 throughout, done 8 cycles after start, both ok=1.
REQ-031 waitrequest stuck at 1 -> timeout=1, done=1, id_ok=0 after 16 stall cycles, avm_read=0 afterwards.
REQ-032 reset_n pulled low while in RD_TS -> avm_read=0 and all outputs 0 in the same cycle, IDLE after release, and a new start completes normally.
REQ-033 start pulsed in RD_ID and again in DONE -> first pulse ignored, second pulse restarts with flags cleared.
